// File: rtl/frame_ctrl.sv
`timescale 1ns/1ps
// frame_ctrl: frame sequencer for the grayscale/Sobel pixel path.
// Admits width*height source pixels per started frame, registers them into
// the RGB-to-gray datapath and marks the datapath's output stream with
// start-of-frame / end-of-line / end-of-frame qualifiers.
module frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 12,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CW-1:0]         width_i,
  input  logic [CW-1:0]         height_i,
  input  logic                  pix_valid_i,
  input  logic [DATA_WIDTH-1:0] red_i,
  input  logic [DATA_WIDTH-1:0] green_i,
  input  logic [DATA_WIDTH-1:0] blue_i,
  output logic                  pix_ready_o,
  output logic [DATA_WIDTH-1:0] red_o,
  output logic [DATA_WIDTH-1:0] green_o,
  output logic [DATA_WIDTH-1:0] blue_o,
  output logic                  dp_valid_o,
  input  logic                  gray_valid_i,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_err;
  logic                  w_err_next;

  logic [CW-1:0]         r_w_m1;
  logic [CW-1:0]         r_h_m1;
  logic [CW-1:0]         r_in_col;
  logic [CW-1:0]         r_in_row;
  logic [CW-1:0]         r_out_col;
  logic [CW-1:0]         r_out_row;
  logic [IW-1:0]         r_idle_cnt;
  logic [IW-1:0]         w_idle_next;

  logic                  r_dp_valid;
  logic [DATA_WIDTH-1:0] r_red;
  logic [DATA_WIDTH-1:0] r_green;
  logic [DATA_WIDTH-1:0] r_blue;

  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_accept;
  logic                  w_in_col_last;
  logic                  w_in_row_last;
  logic                  w_last_accept;
  logic                  w_count_en;
  logic                  w_out_col_last;
  logic                  w_out_row_last;
  logic                  w_sof;
  logic                  w_eol;
  logic                  w_eof;
  logic                  w_stray;
  logic                  w_timeout;

  // Decode of handshakes, counter terminal values and frame markers.
  // Markers are only qualified while a frame is being counted, so stray
  // samples (e.g. in-flight data after a reset) never look like a frame edge.
  always_comb begin
    w_start_ok     = start_i && (width_i != {CW{1'b0}}) && (height_i != {CW{1'b0}});
    w_start_bad    = start_i && !w_start_ok;
    w_accept       = (r_state == S_ACTIVE) && pix_valid_i;
    w_in_col_last  = (r_in_col == r_w_m1);
    w_in_row_last  = (r_in_row == r_h_m1);
    w_last_accept  = w_accept && w_in_col_last && w_in_row_last;
    w_count_en     = gray_valid_i && ((r_state == S_ACTIVE) || (r_state == S_DRAIN));
    w_out_col_last = (r_out_col == r_w_m1);
    w_out_row_last = (r_out_row == r_h_m1);
    w_sof          = w_count_en && (r_out_col == {CW{1'b0}}) && (r_out_row == {CW{1'b0}});
    w_eol          = w_count_en && w_out_col_last;
    w_eof          = w_eol && w_out_row_last;
    w_stray        = gray_valid_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Idle counter next value: cycles elapsed since the last gray sample,
  // the sample's own edge counting as the first, saturating at TIMEOUT.
  // The abort therefore lands exactly TIMEOUT cycles after the last sample.
  always_comb begin
    w_idle_next = r_idle_cnt;
    if (gray_valid_i) begin
      w_idle_next = IW'(1);
    end else if (r_idle_cnt != IDLE_LIMIT) begin
      w_idle_next = r_idle_cnt + IW'(1);
    end else begin
      w_idle_next = r_idle_cnt;
    end
    w_timeout = (r_state == S_DRAIN) && !gray_valid_i && (w_idle_next == IDLE_LIMIT);
  end

  // Next-state and error-pulse logic of the frame sequencer.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_ACTIVE;
          w_err_next   = w_stray;
        end else begin
          w_state_next = S_IDLE;
          w_err_next   = w_start_bad || w_stray;
        end
      end
      S_ACTIVE: begin
        if (w_eof) begin
          // datapath produced a whole frame before the source finished
          w_state_next = S_IDLE;
          w_err_next   = 1'b1;
        end else if (w_last_accept) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        if (w_eof) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
          w_err_next   = 1'b1;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_err_next   = w_stray;
      end
      default: begin
        w_state_next = S_IDLE;
        w_err_next   = 1'b0;
      end
    endcase
  end

  // State and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
    end
  end

  // Frame dimensions and input/output coordinate counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_m1    <= {CW{1'b0}};
      r_h_m1    <= {CW{1'b0}};
      r_in_col  <= {CW{1'b0}};
      r_in_row  <= {CW{1'b0}};
      r_out_col <= {CW{1'b0}};
      r_out_row <= {CW{1'b0}};
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_w_m1    <= width_i - CW'(1);
      r_h_m1    <= height_i - CW'(1);
      r_in_col  <= {CW{1'b0}};
      r_in_row  <= {CW{1'b0}};
      r_out_col <= {CW{1'b0}};
      r_out_row <= {CW{1'b0}};
    end else begin
      if (w_accept) begin
        if (w_in_col_last) begin
          r_in_col <= {CW{1'b0}};
          r_in_row <= r_in_row + CW'(1);
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end
      if (w_count_en) begin
        if (w_out_col_last) begin
          r_out_col <= {CW{1'b0}};
          r_out_row <= r_out_row + CW'(1);
        end else begin
          r_out_col <= r_out_col + CW'(1);
        end
      end
    end
  end

  // Drain idle counter; only runs while waiting for the datapath to finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= {IW{1'b0}};
    end else if (r_state == S_DRAIN) begin
      r_idle_cnt <= w_idle_next;
    end else begin
      r_idle_cnt <= {IW{1'b0}};
    end
  end

  // Pixel register stage into the datapath; RGB holds between accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_valid <= 1'b0;
      r_red      <= {DATA_WIDTH{1'b0}};
      r_green    <= {DATA_WIDTH{1'b0}};
      r_blue     <= {DATA_WIDTH{1'b0}};
    end else begin
      r_dp_valid <= w_accept;
      if (w_accept) begin
        r_red   <= red_i;
        r_green <= green_i;
        r_blue  <= blue_i;
      end
    end
  end

  assign pix_ready_o  = (r_state == S_ACTIVE);
  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = (r_state == S_DONE);
  assign err_o        = r_err;
  assign dp_valid_o   = r_dp_valid;
  assign red_o        = r_red;
  assign green_o      = r_green;
  assign blue_o       = r_blue;
  assign sof_o        = w_sof;
  assign eol_o        = w_eol;
  assign eof_o        = w_eof;

endmodule
